// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vpu_pkg
// Brief    : Shared opcodes, FSM encoding, Q8.8 saturation constants/helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vpu_pkg;

    localparam logic [3:0]  OP_ADD   = 4'd0;
    localparam logic [3:0]  OP_SUB   = 4'd1;
    localparam logic [3:0]  OP_SCALE = 4'd2;
    localparam logic [3:0]  OP_DOT   = 4'd3;

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_EXEC   = 2'd1;
    localparam logic [1:0]  S_WB     = 2'd2;

    localparam logic [15:0] C_Q88_POS   = 16'h7FFF;
    localparam logic [15:0] C_Q88_NEG   = 16'h8000;
    localparam int          C_ERR_BIT   = 15;
    localparam int          C_OVF_BIT   = 14;

    // Q8.8 extract fits only when bits [31:23] are pure sign extension.
    function automatic logic q88_ovf(input logic [31:0] p);
        return !((&p[31:23]) || !(|p[31:23]));
    endfunction

    function automatic logic [15:0] q88_sat(input logic [31:0] p);
        if (q88_ovf(p))
            return p[31] ? C_Q88_NEG : C_Q88_POS;
        return p[23:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_mul_sat.sv
`default_nettype none
// ============================================================================
// Module   : vpu_mul_sat
// Brief    : Combinational signed 16x16 multiply with saturated Q8.8 result.
// Revision : 1.0 - initial release
// ============================================================================
module vpu_mul_sat
    import vpu_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_prod,
    output logic [15:0] o_q88,
    output logic        o_sat
);

    logic signed [31:0] w_prod;

    assign w_prod = $signed(i_a) * $signed(i_b);
    assign o_prod = w_prod;
    assign o_q88  = q88_sat(w_prod);
    assign o_sat  = q88_ovf(w_prod);

endmodule
`default_nettype wire

// File: rtl/vpu_vector_unit.sv
`default_nettype none
// ============================================================================
// Module   : vpu_vector_unit
// Brief    : CPU-side VPU responder; 3-element fixed-point vector ops.
// Revision : 1.0 - initial release
// ============================================================================
module vpu_vector_unit
    import vpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        VPU_start,
    input  logic [15:0] V0_in,
    input  logic [15:0] V1_in,
    input  logic [15:0] V2_in,
    input  logic [15:0] V3_in,
    input  logic [15:0] V4_in,
    input  logic [15:0] V5_in,
    input  logic [15:0] V6_in,
    input  logic [15:0] V7_in,
    input  logic [15:0] RO_in,
    output logic        VPU_rdy,
    output logic        we_VPU,
    output logic [15:0] V0_out,
    output logic [15:0] V1_out,
    output logic [15:0] V2_out,
    output logic [15:0] V3_out,
    output logic [15:0] V4_out,
    output logic [15:0] V5_out,
    output logic [15:0] V6_out,
    output logic [15:0] V7_out,
    output logic [15:0] RO_out
);

    logic [1:0]  r_state, w_state_next;
    logic [1:0]  r_idx;
    logic [3:0]  r_op;
    logic [31:0] r_acc;
    logic        r_ovf;
    logic [15:0] r_v    [8];
    logic [15:0] r_vout [8];
    logic [15:0] r_ro;

    logic [15:0] w_vin   [8];
    logic [15:0] w_vnext [8];
    logic [2:0]  w_aidx, w_bidx;
    logic [15:0] w_a, w_b, w_sum, w_dif, w_q88, w_elem, w_ro_wb, w_ro_err;
    logic [31:0] w_prod, w_acc_next;
    logic        w_sat, w_elem_ovf, w_legal, w_last;
    logic        w_unused_ro;

    assign w_vin[0] = V0_in;  assign w_vin[1] = V1_in;
    assign w_vin[2] = V2_in;  assign w_vin[3] = V3_in;
    assign w_vin[4] = V4_in;  assign w_vin[5] = V5_in;
    assign w_vin[6] = V6_in;  assign w_vin[7] = V7_in;
    assign w_unused_ro = ^RO_in[15:4];

    assign w_legal = (RO_in[3:0] <= OP_DOT);
    assign w_last  = (r_idx == 2'd2);
    assign w_aidx  = {1'b0, r_idx};
    assign w_bidx  = {1'b0, r_idx} + 3'd3;
    assign w_a     = r_v[w_aidx];
    assign w_b     = (r_op == OP_SCALE) ? r_v[6] : r_v[w_bidx];
    assign w_sum   = w_a + w_b;
    assign w_dif   = w_a - w_b;
    assign w_acc_next = r_acc + w_prod;

    vpu_mul_sat u_mul (
        .i_a    (w_a),
        .i_b    (w_b),
        .o_prod (w_prod),
        .o_q88  (w_q88),
        .o_sat  (w_sat)
    );

    always_comb begin
        w_elem     = w_a;
        w_elem_ovf = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_elem     = w_sum;
                w_elem_ovf = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
            end
            OP_SUB: begin
                w_elem     = w_dif;
                w_elem_ovf = (w_a[15] != w_b[15]) && (w_dif[15] != w_a[15]);
            end
            OP_SCALE: begin
                w_elem     = w_q88;
                w_elem_ovf = w_sat;
            end
            default: ;
        endcase
    end

    // Current element result merged into the latched vector; DOT leaves it untouched.
    always_comb begin
        for (int i = 0; i < 8; i++)
            w_vnext[i] = r_v[i];
        if (r_op != OP_DOT)
            w_vnext[w_aidx] = w_elem;
    end

    always_comb begin
        w_ro_wb = '0;
        if (r_op == OP_DOT) begin
            w_ro_wb = q88_sat(w_acc_next);
        end else begin
            w_ro_wb[C_OVF_BIT] = r_ovf | w_elem_ovf;
            w_ro_wb[3:0]       = r_op;
        end
        w_ro_err            = '0;
        w_ro_err[C_ERR_BIT] = 1'b1;
        w_ro_err[3:0]       = RO_in[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (VPU_start) w_state_next = w_legal ? S_EXEC : S_WB;
            S_EXEC:  if (w_last)    w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        VPU_rdy = (r_state == S_IDLE);
        we_VPU  = (r_state == S_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_op  <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_ro  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_v[i]    <= '0;
                r_vout[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (VPU_start) begin
                        r_v   <= w_vin;
                        r_op  <= RO_in[3:0];
                        r_acc <= '0;
                        r_idx <= '0;
                        r_ovf <= 1'b0;
                        if (!w_legal) begin
                            r_vout <= w_vin;
                            r_ro   <= w_ro_err;
                        end
                    end
                end
                S_EXEC: begin
                    r_v   <= w_vnext;
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_elem_ovf;
                    r_idx <= r_idx + 2'd1;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_vout <= w_vnext;
                        r_ro   <= w_ro_wb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign V0_out = r_vout[0];  assign V1_out = r_vout[1];
    assign V2_out = r_vout[2];  assign V3_out = r_vout[3];
    assign V4_out = r_vout[4];  assign V5_out = r_vout[5];
    assign V6_out = r_vout[6];  assign V7_out = r_vout[7];
    assign RO_out = r_ro;

endmodule
`default_nettype wire

// File: tb/tb_vpu_vector_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vpu_vector_unit
// Brief    : Scoreboard bench for vpu_vector_unit using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vpu_vector_unit;

    typedef logic [7:0][15:0] vec_t;
    typedef struct packed {
        vec_t        v;
        logic [15:0] ro;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        VPU_start = 1'b0;
    logic [15:0] vin [8];
    logic [15:0] RO_in = '0;
    logic        VPU_rdy, we_VPU;
    logic [15:0] vout [8];
    logic [15:0] RO_out;
    logic [31:0] cyc = '0;

    exp_t q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vpu_vector_unit dut (
        .clk(clk), .rst_n(rst_n), .VPU_start(VPU_start),
        .V0_in(vin[0]), .V1_in(vin[1]), .V2_in(vin[2]), .V3_in(vin[3]),
        .V4_in(vin[4]), .V5_in(vin[5]), .V6_in(vin[6]), .V7_in(vin[7]),
        .RO_in(RO_in), .VPU_rdy(VPU_rdy), .we_VPU(we_VPU),
        .V0_out(vout[0]), .V1_out(vout[1]), .V2_out(vout[2]), .V3_out(vout[3]),
        .V4_out(vout[4]), .V5_out(vout[5]), .V6_out(vout[6]), .V7_out(vout[7]),
        .RO_out(RO_out)
    );

    function automatic vec_t mk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
        vec_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write-back must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && we_VPU) begin
            if (q.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_cycle", cyc, e.cyc);
                for (int i = 0; i < 8; i++)
                    chk($sformatf("V%0d_out", i), {16'h0, vout[i]}, {16'h0, e.v[i]});
                chk("RO_out", {16'h0, RO_out}, {16'h0, e.ro});
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        while (!VPU_rdy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!VPU_rdy) chk("rdy_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input vec_t v, input logic [15:0] ro_in, input vec_t ev,
                         input logic [15:0] ero, input bit legal, input bit mid_pulse);
        int   n;
        exp_t e;
        wait_rdy();
        for (int i = 0; i < 8; i++) vin[i] = v[i];
        RO_in     = ro_in;
        VPU_start = 1'b1;
        @(posedge clk); #1;
        e.v   = ev;
        e.ro  = ero;
        e.cyc = legal ? cyc + 3 : cyc;
        q.push_back(e);
        VPU_start = 1'b0;
        for (int i = 0; i < 8; i++) vin[i] = 16'($urandom);
        RO_in = 16'($urandom);
        chk("rdy_low_after_accept", {31'h0, VPU_rdy}, 32'd0);
        n = 0;
        while (!VPU_rdy && n < 20) begin
            if (mid_pulse && n == 1) begin
                RO_in = 16'h0000;
                VPU_start = 1'b1;
            end
            if (n == 2) VPU_start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        VPU_start = 1'b0;
        chk("busy_cycles", n, legal ? 32'd4 : 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) vin[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", {31'h0, VPU_rdy}, 32'd1);
        chk("reset_we", {31'h0, we_VPU}, 32'd0);
        chk("reset_RO", {16'h0, RO_out}, 32'd0);
        chk("reset_V0", {16'h0, vout[0]}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD
        issue(mk(16'h1, 16'h2, 16'h3, 16'h10, 16'h20, 16'h30, 16'h1234, 16'h5678), 16'h0000,
              mk(16'h11, 16'h22, 16'h33, 16'h10, 16'h20, 16'h30, 16'h1234, 16'h5678), 16'h0000, 1, 0);
        // SUB with overflow on element 0
        issue(mk(16'h8000, 16'h5, 16'h0, 16'h1, 16'h3, 16'h1, 16'h0, 16'h0), 16'h0001,
              mk(16'h7FFF, 16'h2, 16'hFFFF, 16'h1, 16'h3, 16'h1, 16'h0, 16'h0), 16'h4001, 1, 0);
        // SCALE by 2.0, element 2 saturates high
        issue(mk(16'h0200, 16'h0100, 16'h7000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0200, 16'hDDDD), 16'h0002,
              mk(16'h0400, 16'h0200, 16'h7FFF, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0200, 16'hDDDD), 16'h4002, 1, 0);
        // SCALE by 1.5, negative values, element 2 saturates low
        issue(mk(16'hFF00, 16'h0100, 16'h8000, 16'h1, 16'h2, 16'h3, 16'h0180, 16'h4), 16'h0002,
              mk(16'hFE80, 16'h0180, 16'h8000, 16'h1, 16'h2, 16'h3, 16'h0180, 16'h4), 16'h4002, 1, 0);
        // DOT with a stray start during EXEC
        issue(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h7777, 16'h8888), 16'h0003,
              mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h7777, 16'h8888), 16'h0600, 1, 1);
        // DOT saturating positive
        issue(mk(16'h7000, 16'h0, 16'h0, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0), 16'h0003,
              mk(16'h7000, 16'h0, 16'h0, 16'h7000, 16'h0, 16'h0, 16'h0, 16'h0), 16'h7FFF, 1, 0);
        // DOT negative: -2.0 + 0.5
        issue(mk(16'hFF00, 16'h0080, 16'h0, 16'h0200, 16'h0100, 16'h0, 16'h9, 16'h9), 16'h0003,
              mk(16'hFF00, 16'h0080, 16'h0, 16'h0200, 16'h0100, 16'h0, 16'h9, 16'h9), 16'hFE80, 1, 0);
        // Illegal opcodes
        issue(mk(16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hA4, 16'hA5, 16'hA6, 16'hA7), 16'h0009,
              mk(16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hA4, 16'hA5, 16'hA6, 16'hA7), 16'h8009, 0, 0);
        issue(mk(16'hB0, 16'hB1, 16'hB2, 16'hB3, 16'hB4, 16'hB5, 16'hB6, 16'hB7), 16'h123F,
              mk(16'hB0, 16'hB1, 16'hB2, 16'hB3, 16'hB4, 16'hB5, 16'hB6, 16'hB7), 16'h800F, 0, 0);
        // Back-to-back ADD, upper RO_in bits ignored, overflow on element 0
        issue(mk(16'h7FFF, 16'h1, 16'h1, 16'h0001, 16'h1, 16'h1, 16'h0, 16'h0), 16'hFFF0,
              mk(16'h8000, 16'h2, 16'h2, 16'h0001, 16'h1, 16'h1, 16'h0, 16'h0), 16'h4000, 1, 0);

        // Reset two cycles into an ADD: command aborted, no write-back
        wait_rdy();
        for (int i = 0; i < 8; i++) vin[i] = 16'h0011;
        RO_in = 16'h0000;
        VPU_start = 1'b1;
        @(posedge clk); #1;
        VPU_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_we", {31'h0, we_VPU}, 32'd0);
        chk("abort_RO", {16'h0, RO_out}, 32'd0);
        chk("abort_V0", {16'h0, vout[0]}, 32'd0);
        chk("abort_V7", {16'h0, vout[7]}, 32'd0);
        chk("abort_rdy", {31'h0, VPU_rdy}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_abort_rdy", {31'h0, VPU_rdy}, 32'd1);

        issue(mk(16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1), 16'h0001,
              mk(16'h0, 16'h0, 16'h0, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1), 16'h0001, 1, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_expectations", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
